// File: rtl/priority_codec_pkg.sv
// ---------------------------------------------------------------------------
// priority_codec_pkg
// Shared definitions for the priority encoder / decoder family.
//   CODE_W    : width of the encoded index
//   ONEHOT_W  : width of the one-hot vector
//   CNT_W     : width of the hold/gap timer
//   state_t   : decoder FSM states (IDLE, DRIVE, GAP)
//   decode()  : index -> one-hot conversion
// ---------------------------------------------------------------------------
package priority_codec_pkg;

    localparam int CODE_W   = 2;
    localparam int ONEHOT_W = 4;
    localparam int CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Exactly one bit set for every legal code.
    function automatic logic [ONEHOT_W-1:0] decode(input logic [CODE_W-1:0] code);
        logic [ONEHOT_W-1:0] onehot;
        onehot = '0;
        for (int i = 0; i < ONEHOT_W; i++) begin
            if (code == CODE_W'(i)) begin
                onehot[i] = 1'b1;
            end
        end
        return onehot;
    endfunction

endpackage

// File: rtl/priority_decoder4_timer.sv
// ---------------------------------------------------------------------------
// priority_decoder4_timer
// 8-bit down-counter used to time the DRIVE and GAP phases.
// Ports:
//   clk, rst  : clock and synchronous active-high reset (count -> 0)
//   load      : load load_val this edge (takes priority over en)
//   load_val  : value to load
//   en        : count down by one; saturates at zero (no wrap)
//   count     : current counter value
//   done      : count == 0
// ---------------------------------------------------------------------------
module priority_decoder4_timer
    import priority_codec_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_val;
        end else if (en && (count_reg != '0)) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
    assign done  = (count_reg == '0);

endmodule

// File: rtl/priority_decoder4.sv
// ---------------------------------------------------------------------------
// priority_decoder4
// Accepts a 2-bit index, then drives its registered one-hot decode for
// HOLD_CYCLES cycles, followed by GAP_CYCLES idle cycles before the next
// accept. abort cancels the current output on the next edge.
//
// Parameters:
//   HOLD_CYCLES : cycles y/y_valid are held (1..255)
//   GAP_CYCLES  : idle cycles after each hold (0..255)
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   a           : index to decode
//   in_valid    : a is valid
//   in_ready    : block can accept this cycle (IDLE, no abort, no reset)
//   abort       : cancel current output / block acceptance
//   y, y_valid  : registered one-hot output and its qualifier
//   busy        : FSM not in IDLE
// Optional feature (macro PRIORITY_DECODER4_STICKY_EN):
//   seen_clr    : clear the sticky history
//   seen        : registered OR of every y issued since the last clear
// ---------------------------------------------------------------------------
module priority_decoder4
    import priority_codec_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CODE_W-1:0]   a,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                abort,
`ifdef PRIORITY_DECODER4_STICKY_EN
    input  logic                seen_clr,
    output logic [ONEHOT_W-1:0] seen,
`endif
    output logic [ONEHOT_W-1:0] y,
    output logic                y_valid,
    output logic                busy
);

    // Counter is loaded with N-1 on entry so a phase lasts exactly N cycles.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam bit               HAS_GAP   = (GAP_CYCLES != 0);
    localparam logic [CNT_W-1:0] GAP_LOAD  = HAS_GAP ? CNT_W'(GAP_CYCLES - 1) : '0;

    state_t              state_reg, state_next;
    logic [CODE_W-1:0]   code_reg, code_next;
    logic [ONEHOT_W-1:0] y_reg, y_next;
    logic                y_valid_reg, y_valid_next;

    logic                tmr_load;
    logic [CNT_W-1:0]    tmr_load_val;
    logic                tmr_en;
    logic [CNT_W-1:0]    tmr_count;
    logic                tmr_done;
    logic                accept;

    priority_decoder4_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .count    (tmr_count),
        .done     (tmr_done)
    );

    // rst is included so nothing looks acceptable while reset is held.
    assign in_ready = (state_reg == IDLE) && !abort && !rst;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next   = state_reg;
        code_next    = code_reg;
        y_next       = y_reg;
        y_valid_next = y_valid_reg;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_en       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next   = DRIVE;
                    code_next    = a;
                    y_next       = decode(a);
                    y_valid_next = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = HOLD_LOAD;
                end
            end

            DRIVE: begin
                if (abort) begin
                    // Return the timer to zero so IDLE always sees a clean counter.
                    state_next   = IDLE;
                    y_next       = '0;
                    y_valid_next = 1'b0;
                    tmr_load     = 1'b1;
                end else if (tmr_done) begin
                    y_next       = '0;
                    y_valid_next = 1'b0;
                    if (HAS_GAP) begin
                        state_next   = GAP;
                        tmr_load     = 1'b1;
                        tmr_load_val = GAP_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end

            GAP: begin
                if (abort) begin
                    state_next = IDLE;
                    tmr_load   = 1'b1;
                end else if (tmr_done) begin
                    state_next = IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            default: begin
                state_next   = IDLE;
                y_next       = '0;
                y_valid_next = 1'b0;
                tmr_load     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            code_reg    <= '0;
            y_reg       <= '0;
            y_valid_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            code_reg    <= code_next;
            y_reg       <= y_next;
            y_valid_reg <= y_valid_next;
        end
    end

    assign y       = y_reg;
    assign y_valid = y_valid_reg;
    assign busy    = (state_reg != IDLE);

`ifdef PRIORITY_DECODER4_STICKY_EN
    // History updates on the same edge the new y is registered, so a clear
    // coinciding with an accept leaves exactly that y in the history.
    logic [ONEHOT_W-1:0] seen_reg;
    logic [ONEHOT_W-1:0] seen_next;

    always_comb begin
        seen_next = seen_clr ? '0 : seen_reg;
        if (accept) begin
            seen_next = seen_next | y_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_reg <= '0;
        end else begin
            seen_reg <= seen_next;
        end
    end

    assign seen = seen_reg;
`endif

endmodule
